booth_final_cpa: RTL and testbench



---
 rtl/booth_pkg.sv | 14 +
 rtl/cpa_add.sv | 28 ++
 rtl/booth_final_cpa.sv | 127 ++++++++++++
 tb/tb_booth_final_cpa.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// ----------------------------------------------------------------------------
// booth_pkg
// Shared sizing constants for the Booth multiplier datapath: the partial
// product generator, the 4:2 compressor tree and the final carry-propagate
// adder all size themselves from these.
//   PROD_W : product width in bits (even, >= 4)
//   LO_W   : width of the low-half adder in the final CPA
// ----------------------------------------------------------------------------
package booth_pkg;

   localparam int PROD_W = 32;
   localparam int LO_W   = PROD_W / 2;

endpackage : booth_pkg

// File: rtl/cpa_add.sv
// ----------------------------------------------------------------------------
// cpa_add
// Purely combinational N-bit binary adder with carry in and carry out.
// Ports:
//   a  [N-1:0] : addend
//   b  [N-1:0] : addend
//   ci         : carry into bit 0
//   s  [N-1:0] : (a + b + ci) mod 2^N
//   co         : carry out of bit N-1
// ----------------------------------------------------------------------------
module cpa_add #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co
);

   logic [N:0] full;

   // One extra bit of headroom captures the carry out.
   assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
   assign s    = full[N-1:0];
   assign co   = full[N];

endmodule : cpa_add

// File: rtl/booth_final_cpa.sv
// ----------------------------------------------------------------------------
// booth_final_cpa
// Final carry-propagate adder of the Booth multiplier. Resolves the redundant
// sum/carry pair from the 4:2 compressor tree into a binary product using a
// two-stage split adder (low half in stage 1, high half plus the low-half
// carry in stage 2). Valid/ready handshake on both sides with full
// backpressure; one result per cycle when the consumer keeps up.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : sum/carry pair presented by the compressor tree
//   in_ready   : stage can accept this cycle (combinational from out_ready)
//   sum_vec    : tree sum vector, bit i weight 2^i
//   carry_vec  : tree carry vector, bit i weight 2^(i+1)
//   out_valid  : product valid
//   out_ready  : consumer accepts product
//   product    : (sum_vec + (carry_vec << 1)) mod 2^W
//   cout       : carry out of bit W-1 of that addition
// ----------------------------------------------------------------------------
module booth_final_cpa #(
   parameter int W    = booth_pkg::PROD_W,
   parameter int LO_W = W / 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] sum_vec,
   input  logic [W-1:0] carry_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] product,
   output logic         cout
);

   localparam int HI_W = W - LO_W;

   // Pipeline state
   logic            s1_valid_q;
   logic [LO_W-1:0] s1_lo_q;
   logic            s1_c_q;
   logic [HI_W-1:0] s1_a_hi_q;
   logic [HI_W-1:0] s1_b_hi_q;
   logic            out_valid_q;
   logic [W-1:0]    product_q;
   logic            cout_q;

   // Next-state values from the two adder halves
   logic [LO_W-1:0] s1_lo_d;
   logic            s1_c_d;
   logic [HI_W-1:0] prod_hi_d;
   logic            cout_d;

   logic         s1_en;
   logic         s2_en;
   logic [W-1:0] b_vec;

   // The carry vector's bit i carries weight 2^(i+1). Its MSB would land on
   // 2^W, outside the modular result, and is deliberately dropped so it can
   // never leak into cout.
   logic unused_carry_msb;
   assign unused_carry_msb = carry_vec[W-1];
   assign b_vec            = {carry_vec[W-2:0], 1'b0};

   // Ready propagates combinationally back through both stages, so a full
   // pipe that drains this cycle can still accept a new pair.
   assign s2_en    = !out_valid_q | out_ready;
   assign s1_en    = !s1_valid_q | s2_en;
   assign in_ready = s1_en;

   cpa_add #(.N(LO_W)) u_add_lo (
      .a  (sum_vec[LO_W-1:0]),
      .b  (b_vec[LO_W-1:0]),
      .ci (1'b0),
      .s  (s1_lo_d),
      .co (s1_c_d)
   );

   cpa_add #(.N(HI_W)) u_add_hi (
      .a  (s1_a_hi_q),
      .b  (s1_b_hi_q),
      .ci (s1_c_q),
      .s  (prod_hi_d),
      .co (cout_d)
   );

   // Stage 1: low-half add, high-half operands registered for stage 2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_lo_q    <= '0;
         s1_c_q     <= 1'b0;
         s1_a_hi_q  <= '0;
         s1_b_hi_q  <= '0;
      end else if (s1_en) begin
         s1_valid_q <= in_valid;
         // Payload only moves with a real transfer so it stays stable
         // while the stage is empty.
         if (in_valid) begin
            s1_lo_q   <= s1_lo_d;
            s1_c_q    <= s1_c_d;
            s1_a_hi_q <= sum_vec[W-1:LO_W];
            s1_b_hi_q <= b_vec[W-1:LO_W];
         end
      end
   end

   // Stage 2: high-half add with the low-half carry, result registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         product_q   <= '0;
         cout_q      <= 1'b0;
      end else if (s2_en) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            product_q <= {prod_hi_d, s1_lo_q};
            cout_q    <= cout_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign product   = product_q;
   assign cout      = cout_q;

endmodule : booth_final_cpa

// File: tb/tb_booth_final_cpa.sv
// ----------------------------------------------------------------------------
// tb_booth_final_cpa
// Scoreboard bench for booth_final_cpa (W = 32). Accepted pairs push their
// expected product/cout into a queue; an independent monitor pops and
// compares whenever an output transfer is about to happen.
// ----------------------------------------------------------------------------
module tb_booth_final_cpa;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] prod;
      logic         co;
      int           acc_cyc;
      bit           chk_lat;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] sum_vec;
   logic [W-1:0] carry_vec;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] product;
   logic         cout;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   booth_final_cpa #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_vec   (sum_vec),
      .carry_vec (carry_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .cout      (cout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain unsigned arithmetic; the carry vector contributes
   // twice its value, with its top bit falling outside the 2^W window.
   function automatic exp_t ref_model(input logic [W-1:0] s, input logic [W-1:0] c,
                                      input int acc, input bit lat);
      exp_t e;
      longint unsigned t;
      t = longint'(s) + 2 * (longint'(c) % (64'd1 << (W - 1)));
      e.prod    = t[W-1:0];
      e.co      = t[W];
      e.acc_cyc = acc;
      e.chk_lat = lat;
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Present one pair starting at the next falling edge and hold it until
   // the DUT is ready; the transfer happens on the following rising edge.
   task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, input bit lat);
      int guard;
      @(negedge clk);
      in_valid  = 1'b1;
      sum_vec   = s;
      carry_vec = c;
      #1;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!in_ready) begin
         check("send_timeout", 64'(in_ready), 64'd1);
      end else begin
         sb.push_back(ref_model(s, c, cyc, lat));
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 60) begin
         idle();
         guard++;
      end
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: sample mid low-phase, where handshake signals are settled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 64'(out_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               check("product", 64'(product), 64'(e.prod));
               check("cout", 64'(cout), 64'(e.co));
               if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd2);
            end
         end
      end
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      sum_vec   = '0;
      carry_vec = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_product", 64'(product), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);

      // Directed vectors: basic, cross-half carry, ignored carry MSB
      send(32'h0000_0005, 32'h0000_0001, 1'b1);
      idle();
      idle();
      send(32'h0000_FFFF, 32'h0000_0001, 1'b1);
      send(32'hFFFF_FFFF, 32'h8000_0001, 1'b1);
      send(32'h7FFF_FFFF, 32'hC000_0000, 1'b1);
      drain();

      // Backpressure: A and B fill the pipe, C must wait
      @(negedge clk);
      out_ready = 1'b0;
      send(32'd1, 32'd0, 1'b0);
      send(32'd2, 32'd0, 1'b0);
      @(negedge clk);
      in_valid  = 1'b1;
      sum_vec   = 32'd3;
      carry_vec = 32'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_in_ready_low", 64'(in_ready), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_product_hold", 64'(product), 64'd1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      check("bp_accept_on_drain", 64'(in_ready), 64'd1);
      if (in_ready) sb.push_back(ref_model(32'd3, 32'd0, cyc, 1'b1));
      drain();

      // Streaming: random back-to-back pairs
      for (int i = 0; i < 100; i++) begin
         send($urandom, $urandom, 1'b1);
      end
      drain();

      // Reset mid-flight with two results in the pipe
      @(negedge clk);
      out_ready = 1'b0;
      send($urandom, $urandom, 1'b0);
      send($urandom, $urandom, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      sb.delete();
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_product", 64'(product), 64'd0);
      check("midrst_cout", 64'(cout), 64'd0);
      @(negedge clk);
      #3;
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #2;
         check("post_rst_no_stale", 64'(out_valid), 64'd0);
      end
      send(32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_booth_final_cpa
